// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads instruction memory combinationally
// and holds the fetched word in an IF/ID register handed to decode.
module fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              id_ready,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic              halted,
    output logic              misalign,
    output logic [15:0]       fetch_count,
    output logic              dbg_state
);

    localparam logic [31:0] EBREAK = 32'h00100073;
    localparam logic [31:0] NOP    = 32'h00000013;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [ADDR_W-1:0]  r_pc;
    logic               r_if_valid;
    logic [31:0]        r_if_instr;
    logic [ADDR_W-1:0]  r_if_pc;
    logic               r_misalign;
    logic [15:0]        r_fetch_count;

    logic               w_cap;
    logic               w_is_ebreak;
    logic [ADDR_W-1:0]  w_pc_inc;
    logic [ADDR_W-1:0]  w_br_aligned;

    // Handshake: a word moves to decode on a rising edge where if_valid and
    // id_ready are both high and br_taken is low; while if_valid && !id_ready
    // the IF/ID register and the PC hold. A redirect squashes the held word.
    assign w_cap        = (r_state == ST_RUN) && (!r_if_valid || id_ready) && !br_taken;
    assign w_is_ebreak  = (imem_data == EBREAK);
    assign w_pc_inc     = r_pc + ADDR_W'(4);
    assign w_br_aligned = {br_target[ADDR_W-1:2], 2'b00};

    always_comb begin
        w_state_next = r_state;
        if (br_taken) begin
            w_state_next = ST_RUN;
        end else if (w_cap && w_is_ebreak) begin
            w_state_next = ST_HALT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_if_valid    <= 1'b0;
            r_if_instr    <= NOP;
            r_if_pc       <= '0;
            r_misalign    <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            r_misalign <= 1'b0;
            if (br_taken) begin
                r_pc       <= w_br_aligned;
                r_if_valid <= 1'b0;
                r_misalign <= |br_target[1:0];
            end else if (w_cap) begin
                r_if_instr <= imem_data;
                r_if_pc    <= r_pc;
                r_if_valid <= 1'b1;
                r_pc       <= w_pc_inc;
                if (r_fetch_count != 16'hFFFF) begin
                    r_fetch_count <= r_fetch_count + 16'd1;
                end
            end else if (r_if_valid && id_ready) begin
                r_if_valid <= 1'b0;
            end
        end
    end

    assign imem_addr   = r_pc;
    assign if_valid    = r_if_valid;
    assign if_instr    = r_if_instr;
    assign if_pc       = r_if_pc;
    assign halted      = (r_state == ST_HALT);
    assign misalign    = r_misalign;
    assign fetch_count = r_fetch_count;
    assign dbg_state   = r_state;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that sits directly upstream of the instruction memory. It owns the program counter and drives the memory's 8-bit byte address. It captures the 32-bit word returned combinationally into an IF/ID register, which it hands to decode over a valid/ready handshake. It also handles branch redirects from execute, halts on `ebreak`, and keeps a saturating fetch counter.

## Interface
Parameters:
- `ADDR_W`, 8: PC / instruction-memory address width (byte address).
- `RESET_PC`, 8'h00: PC value loaded on reset. Must be a multiple of 4.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `imem_addr`  out  ADDR_W: byte address to instruction memory. Always equals the PC register.
- `imem_data`  in  32: instruction word from memory, valid in the same cycle (combinational read).
- `br_taken`  in  1: redirect request from execute, sampled at the rising edge.
- `br_target`  in  ADDR_W: redirect byte address.
- `id_ready`  in  1: decode accepts `if_instr` this cycle.
- `if_valid`  out  1: `if_instr` / `if_pc` hold a valid fetched instruction.
- `if_instr`  out  32: captured instruction.
- `if_pc`  out  ADDR_W: address of `if_instr`.
- `halted`  out  1: fetch stopped after `ebreak`.
- `misalign`  out  1: one-cycle pulse when an accepted `br_target` has bits [1:0] ≠ 0.
- `fetch_count`  out  16: number of instructions captured since reset, saturating.

## Operation
- State machine with two states, RUN and HALT. Reset enters RUN.
- Capture condition: `cap = (state==RUN) && (!if_valid || id_ready) && !br_taken`.
- On `cap`:
  - `if_instr <= imem_data`, `if_pc <= pc`, `if_valid <= 1`, `pc <= pc + 4`.
  - PC arithmetic is modulo 2^ADDR_W, so 8'hFC wraps to 8'h00.
- If `if_valid && id_ready && !cap`, then `if_valid <= 0` (handed off, nothing new captured).
- If `if_valid && !id_ready`, the IF/ID register and PC hold unchanged.
- Redirect (`br_taken=1`) has priority over capture, stall and HALT:
  - `pc <= {br_target[ADDR_W-1:2], 2'b00}`, `if_valid <= 0`, `state <= RUN`.
  - `misalign <= |br_target[1:0]`. Otherwise `misalign <= 0` every cycle.
- Halt: if `cap` and `imem_data == 32'h00100073` (ebreak):
  - The ebreak word is captured and presented normally.
  - PC advances by 4.
  - `state <= HALT`. In HALT, `cap=0`, `halted=1`, and the PC is frozen.
  - The pending instruction still drains when `id_ready=1`.
  - HALT is left only by a redirect or by `rst`.
- `fetch_count` increments by 1 on each `cap` and saturates at 16'hFFFF.
- Reset values:
  - `pc = RESET_PC` (so `imem_addr = RESET_PC`)
  - `if_valid = 0`, `if_instr = 32'h00000013` (nop), `if_pc = 0`
  - `halted = 0`, `misalign = 0`, `fetch_count = 0`, `state = RUN`
- `rst` has priority over everything, including `br_taken`.

## Timing
- `imem_addr` is registered, with 0 combinational paths from inputs.
- `imem_data` is used in the cycle it is addressed.
- Fetch latency: the instruction at PC is visible on `if_instr` one cycle after `imem_addr` = PC.
- Throughput: with `id_ready` held at 1, one instruction per cycle.
- Redirect penalty:
  - In the cycle after the `br_taken` edge, `if_valid=0` and `imem_addr` = target.
  - The target instruction is valid on the next cycle.
  - Any held instruction is squashed even if `id_ready=1` in the same cycle.
- Reset mid-operation: on the next edge all state returns to the reset values. No instruction survives.
- Outputs `if_*`, `halted`, `misalign` and `fetch_count` are all registered.

## Test plan
1. Reset and stream:
   - Stimulus: load the reference program (0x00: 32'h00100293, 0x04: 32'h00000313, ...), hold `id_ready=1`, release `rst`.
   - Required: `if_instr`/`if_pc` = 32'h00100293/0x00, then 32'h00000313/0x04, then 32'h00600393/0x08 on consecutive cycles. `fetch_count` = 3.
2. Backpressure:
   - Stimulus: drop `id_ready` for 3 cycles while `if_pc`=0x04.
   - Required: `if_instr`, `if_pc`, `imem_addr` (0x08) and `fetch_count` hold. Raising `id_ready` resumes at 0x08 with no duplicate or skipped instruction.
3. Redirect:
   - Stimulus: `br_taken=1`, `br_target`=8'h0C while `if_valid=1` and `id_ready=0`.
   - Required: next cycle `if_valid=0`, `imem_addr`=0x0C. Following cycle `if_pc`=0x0C. Target 8'h0E instead gives `imem_addr`=0x0C and a one-cycle `misalign=1`.
4. Halt:
   - Stimulus: place 32'h00100073 at 0x10.
   - Required: it is presented with `if_pc`=0x10, then `halted=1` and `imem_addr` stays at 0x14. `if_valid` clears after one `id_ready` and `fetch_count` freezes. A redirect to 0x00 clears `halted` and fetching restarts.
5. Wrap and saturation:
   - Stimulus: set `RESET_PC`=8'hFC. Separately, force the counter to 16'hFFFE and fetch 3 instructions.
   - Required: `if_pc` sequence 0xFC, 0x00, 0x04. `fetch_count` sticks at 16'hFFFF.
6. Reset priority:
   - Stimulus: assert `rst` together with `br_taken=1` mid-stream.
   - Required: after the edge, `pc`=`RESET_PC`, `if_valid=0`, `if_instr`=32'h00000013, `misalign=0`, `fetch_count=0`.
